// File: rtl/riscv_bru_pkg.sv
// Shared types for the EX-stage branch resolver.
//   F3_*        : branch condition encodings carried in func3.
//   bru_state_e : resolver FSM states (run / flush after a redirect).
//   bru_upd_t   : one branch-predictor update entry.
package riscv_bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } bru_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] ghr;
    logic        taken;
    logic        is_cf;
    logic        mispredict;
  } bru_upd_t;

endpackage

// File: rtl/bru_update_fifo.sv
// Synchronous FIFO of predictor update entries.
//   clk, rst       : clock, asynchronous active-high reset (empties the FIFO).
//   push_i/entry_i : write request and data; accepted when not full or when popping.
//   pop_i          : read request; ignored when empty.
//   full_o/empty_o : occupancy flags.
//   head_o         : oldest entry (meaningful only when not empty).
module bru_update_fifo
  import riscv_bru_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  bru_upd_t entry_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output bru_upd_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q, count_d;
  bru_upd_t        mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is fine as long as the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: contents are only observed through non-empty state.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= entry_i;
  end

endmodule

// File: rtl/ex_branch_resolver.sv
// EX-stage branch resolver: evaluates BEQ..BGEU/JAL/JALR, compares the actual next PC with
// the predicted one, issues a registered redirect plus a multi-cycle flush on mispredict,
// and queues every resolved outcome toward the branch predictor.
//   Inputs : clk, rst (async, active-high), ex_valid/ex_stall, instruction class and func3,
//            pc_EX/imm_EX, rs1_val/rs2_val, prediction fields, ghr_EX, upd_ready.
//   Outputs: redirect_valid/redirect_pc, flush_IF_ID/flush_ID_EX, stall_req,
//            upd_valid plus upd_* payload.
// Optional: define BRU_PERF_CNT_EN to add saturating perf_branches/perf_mispredicts counters.
module ex_branch_resolver
  import riscv_bru_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned UPD_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        branch_EX,
  input  logic        is_jal_EX,
  input  logic        is_jalr_EX,
  input  logic [2:0]  func3_EX,
  input  logic [31:0] pc_EX,
  input  logic [31:0] imm_EX,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] predicted_pc_EX,
  input  logic        prediction_valid_EX,
  input  logic [31:0] ghr_EX,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        stall_req,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic [31:0] upd_ghr,
  output logic        upd_taken,
  output logic        upd_is_cf,
  output logic        upd_mispredict
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`endif
);

  bru_state_e  state_q;
  logic [2:0]  cnt_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic        is_cf, cond, taken, mispredict, resolve, push, pop, full, empty;
  logic [31:0] target, seq_pc, actual_next, predicted_next;
  bru_upd_t    entry, head;

  always_comb begin
    cond = 1'b0;
    case (func3_EX)
      F3_BEQ:  cond = (rs1_val == rs2_val);
      F3_BNE:  cond = (rs1_val != rs2_val);
      F3_BLT:  cond = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: cond = (rs1_val < rs2_val);
      F3_BGEU: cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  assign is_cf          = branch_EX | is_jal_EX | is_jalr_EX;
  assign taken          = is_jal_EX | is_jalr_EX | (branch_EX & cond);
  assign seq_pc         = pc_EX + 32'd4;
  assign target         = is_jalr_EX ? ((rs1_val + imm_EX) & ~32'h1) : (pc_EX + imm_EX);
  assign actual_next    = taken ? target : seq_pc;
  assign predicted_next = prediction_valid_EX ? predicted_pc_EX : seq_pc;
  assign mispredict     = (actual_next != predicted_next);

  assign stall_req = full & ~upd_ready;
  assign resolve   = ex_valid & ~ex_stall & ~stall_req & (state_q == StRun);
  // Non-CF instructions with a prediction still push so the predictor can drop the alias.
  assign push      = resolve & (is_cf | prediction_valid_EX);
  assign pop       = upd_valid & upd_ready;

  assign entry = '{pc: pc_EX, target: target, ghr: ghr_EX, taken: taken, is_cf: is_cf,
                   mispredict: mispredict};

  bru_update_fifo #(
    .Depth(UPD_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .entry_i(entry),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );

  // Payload is forced to zero while empty so all outputs read 0 out of reset.
  assign upd_valid      = ~empty;
  assign upd_pc         = upd_valid ? head.pc : '0;
  assign upd_target     = upd_valid ? head.target : '0;
  assign upd_ghr        = upd_valid ? head.ghr : '0;
  assign upd_taken      = upd_valid & head.taken;
  assign upd_is_cf      = upd_valid & head.is_cf;
  assign upd_mispredict = upd_valid & head.mispredict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StRun;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (resolve && mispredict) begin
            state_q          <= StFlush;
            cnt_q            <= 3'(FLUSH_CYCLES - 1);
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= actual_next;
          end
        end
        StFlush: begin
          if (cnt_q == '0) begin
            state_q <= StRun;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_IF_ID    = (state_q == StFlush);
  assign flush_ID_EX    = (state_q == StFlush);

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (resolve && is_cf && (perf_br_q != '1))       perf_br_q  <= perf_br_q + 32'd1;
      if (resolve && mispredict && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_ex_branch_resolver.sv
module tb_ex_branch_resolver;

  localparam int unsigned FlushCycles = 2;
  localparam int unsigned UpdDepth    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, branch_EX, is_jal_EX, is_jalr_EX;
  logic [2:0]  func3_EX;
  logic [31:0] pc_EX, imm_EX, rs1_val, rs2_val, predicted_pc_EX, ghr_EX;
  logic        prediction_valid_EX;
  logic        redirect_valid, flush_IF_ID, flush_ID_EX, stall_req, upd_valid, upd_ready;
  logic [31:0] redirect_pc, upd_pc, upd_target, upd_ghr;
  logic        upd_taken, upd_is_cf, upd_mispredict;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_branch_resolver #(
    .FLUSH_CYCLES(FlushCycles),
    .UPD_DEPTH   (UpdDepth)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_valid           (ex_valid),
    .ex_stall           (ex_stall),
    .branch_EX          (branch_EX),
    .is_jal_EX          (is_jal_EX),
    .is_jalr_EX         (is_jalr_EX),
    .func3_EX           (func3_EX),
    .pc_EX              (pc_EX),
    .imm_EX             (imm_EX),
    .rs1_val            (rs1_val),
    .rs2_val            (rs2_val),
    .predicted_pc_EX    (predicted_pc_EX),
    .prediction_valid_EX(prediction_valid_EX),
    .ghr_EX             (ghr_EX),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .flush_IF_ID        (flush_IF_ID),
    .flush_ID_EX        (flush_ID_EX),
    .stall_req          (stall_req),
    .upd_valid          (upd_valid),
    .upd_ready          (upd_ready),
    .upd_pc             (upd_pc),
    .upd_target         (upd_target),
    .upd_ghr            (upd_ghr),
    .upd_taken          (upd_taken),
    .upd_is_cf          (upd_is_cf),
    .upd_mispredict     (upd_mispredict)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches      (perf_branches),
    .perf_mispredicts   (perf_mispredicts)
`endif
  );

  typedef struct {
    bit          br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1, rs2, ppc;
    bit          pv;
    bit          push, taken;
    logic [31:0] target;
    bit          mis;
    logic [31:0] next;
  } vec_t;

  typedef struct {
    logic [31:0] pc, target, ghr;
    bit          taken, is_cf, mis;
  } ent_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_stall = 0; branch_EX = 0; is_jal_EX = 0; is_jalr_EX = 0;
    func3_EX = 0; pc_EX = 0; imm_EX = 0; rs1_val = 0; rs2_val = 0;
    predicted_pc_EX = 0; prediction_valid_EX = 0; ghr_EX = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    ex_valid = 1; ex_stall = 0;
    branch_EX = v.br; is_jal_EX = v.jal; is_jalr_EX = v.jalr; func3_EX = v.f3;
    pc_EX = v.pc; imm_EX = v.imm; rs1_val = v.rs1; rs2_val = v.rs2;
    predicted_pc_EX = v.ppc; prediction_valid_EX = v.pv; ghr_EX = 32'hA5A5_0000 ^ v.pc;
  endtask

  // Architectural rules for outcome and target, written straight from the ISA.
  function automatic void ref_resolve(input bit br, input bit jal, input bit jalr,
                                      input logic [2:0] f3, input logic [31:0] pc,
                                      input logic [31:0] imm, input logic [31:0] a,
                                      input logic [31:0] b, output bit taken,
                                      output logic [31:0] target);
    bit c;
    case (f3)
      3'd0:    c = (a == b);
      3'd1:    c = (a != b);
      3'd4:    c = ($signed(a) < $signed(b));
      3'd5:    c = ($signed(a) >= $signed(b));
      3'd6:    c = (a < b);
      3'd7:    c = (a >= b);
      default: c = 0;
    endcase
    taken  = jal || jalr || (br && c);
    target = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
  endfunction

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    upd_ready = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    //              br jal jalr f3    pc             imm            rs1            rs2
    //              ppc            pv push taken target        mis next
    tbl[0] = '{1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5,
               32'h120, 1, 1, 1, 32'h120, 0, 32'h120};
    tbl[1] = '{1, 0, 0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1,
               32'h0, 0, 1, 1, 32'h240, 1, 32'h240};
    tbl[2] = '{0, 0, 1, 3'b000, 32'h400, 32'h4, 32'h1003, 32'h0,
               32'h1004, 1, 1, 1, 32'h1006, 1, 32'h1006};
    tbl[3] = '{0, 0, 0, 3'b000, 32'h300, 32'h0, 32'h0, 32'h0,
               32'h500, 1, 1, 0, 32'h300, 1, 32'h304};
    tbl[4] = '{1, 0, 0, 3'b110, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'd1,
               32'h0, 0, 1, 0, 32'h510, 0, 32'h504};
    tbl[5] = '{1, 0, 0, 3'b101, 32'h600, 32'hFFFF_FFF0, 32'h8000_0000, 32'h8000_0000,
               32'h5F0, 1, 1, 1, 32'h5F0, 0, 32'h5F0};
    tbl[6] = '{0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0,
               32'h10, 1, 1, 1, 32'h10, 0, 32'h10};
    tbl[7] = '{1, 0, 0, 3'b010, 32'h700, 32'h8, 32'h0, 32'h0,
               32'h0, 0, 1, 0, 32'h708, 0, 32'h704};
    tbl[8] = '{0, 0, 0, 3'b000, 32'h800, 32'h0, 32'h0, 32'h0,
               32'h0, 0, 0, 0, 32'h800, 0, 32'h804};
    tbl[9] = '{1, 0, 0, 3'b001, 32'h900, 32'h10, 32'd3, 32'd3,
               32'h910, 1, 1, 0, 32'h910, 1, 32'h904};

    rst = 1;
    idle_inputs();
    upd_ready = 1;
    #1;
    check("rst_redirect_valid", {31'b0, redirect_valid}, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_flush", {30'b0, flush_IF_ID, flush_ID_EX}, 0);
    check("rst_upd_valid", {31'b0, upd_valid}, 0);
    check("rst_stall_req", {31'b0, stall_req}, 0);
    tick();
    rst = 0;
    tick();

    // Single-instruction vectors from a quiescent state.
    for (int i = 0; i < 10; i++) begin
      drive_vec(tbl[i]);
      tick();
      idle_inputs();
      check($sformatf("v%0d_redirect_valid", i), {31'b0, redirect_valid}, {31'b0, tbl[i].mis});
      check($sformatf("v%0d_flush", i), {31'b0, flush_IF_ID}, {31'b0, tbl[i].mis});
      if (tbl[i].mis) check($sformatf("v%0d_redirect_pc", i), redirect_pc, tbl[i].next);
      check($sformatf("v%0d_upd_valid", i), {31'b0, upd_valid}, {31'b0, tbl[i].push});
      if (tbl[i].push) begin
        check($sformatf("v%0d_upd_pc", i), upd_pc, tbl[i].pc);
        check($sformatf("v%0d_upd_target", i), upd_target, tbl[i].target);
        check($sformatf("v%0d_upd_flags", i),
              {29'b0, upd_taken, upd_is_cf, upd_mispredict},
              {29'b0, tbl[i].taken, (tbl[i].br | tbl[i].jal | tbl[i].jalr), tbl[i].mis});
      end
      repeat (4) tick();
    end

    // Mispredict: valid instruction during FLUSH is ignored, then resolves once back in RUN.
    drive_vec(tbl[1]);
    tick();
    check("fl_redirect_n1", {31'b0, redirect_valid}, 1);
    check("fl_redirect_pc_n1", redirect_pc, 32'h240);
    check("fl_flush_n1", {30'b0, flush_IF_ID, flush_ID_EX}, 32'd3);
    drive_vec(tbl[3]);
    tick();
    check("fl_redirect_n2", {31'b0, redirect_valid}, 0);
    check("fl_flush_n2", {30'b0, flush_IF_ID, flush_ID_EX}, 32'd3);
    check("fl_no_push_n2", {31'b0, upd_valid}, 0);
    tick();
    check("fl_flush_n3", {30'b0, flush_IF_ID, flush_ID_EX}, 0);
    check("fl_no_redirect_n3", {31'b0, redirect_valid}, 0);
    check("fl_no_push_n3", {31'b0, upd_valid}, 0);
    tick();
    idle_inputs();
    check("fl_fresh_redirect_n4", {31'b0, redirect_valid}, 1);
    check("fl_fresh_redirect_pc_n4", redirect_pc, 32'h304);
    check("fl_fresh_upd_cf_n4", {30'b0, upd_valid, upd_is_cf}, 32'd2);
    repeat (4) tick();

    // Backpressure: fill the FIFO, hold a third instruction, then drain in order.
    upd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_vec('{1, 0, 0, 3'b000, 32'h10 * (i + 1), 32'h8, 32'h0, 32'h0,
                  32'h10 * (i + 1) + 32'h8, 1, 1, 1, 32'h0, 0, 32'h0});
      if (i < 2) tick();
    end
    #1;
    check("bp_stall_full", {31'b0, stall_req}, 1);
    tick();
    check("bp_stall_hold1", {31'b0, stall_req}, 1);
    check("bp_head_hold1", upd_pc, 32'h10);
    tick();
    check("bp_head_hold2", upd_pc, 32'h10);
    upd_ready = 1;
    #1;
    check("bp_stall_release", {31'b0, stall_req}, 0);
    tick();
    idle_inputs();
    check("bp_head_2", upd_pc, 32'h20);
    tick();
    check("bp_head_3", upd_pc, 32'h30);
    check("bp_valid_3", {31'b0, upd_valid}, 1);
    tick();
    check("bp_empty", {31'b0, upd_valid}, 0);

    // Reset one cycle into FLUSH with one entry pending.
    upd_ready = 0;
    drive_vec(tbl[1]);
    tick();
    idle_inputs();
    rst = 1;
    #1;
    check("rr_redirect", {31'b0, redirect_valid}, 0);
    check("rr_flush", {30'b0, flush_IF_ID, flush_ID_EX}, 0);
    check("rr_upd_valid", {31'b0, upd_valid}, 0);
    check("rr_upd_pc", upd_pc, 0);
    tick();
    rst = 0;
    upd_ready = 1;
    drive_vec(tbl[0]);
    tick();
    idle_inputs();
    check("rr_run_push", {31'b0, upd_valid}, 1);
    check("rr_run_pc", upd_pc, 32'h100);
    repeat (3) tick();

    // Randomized traffic against a queue-based reference model.
    do_reset();
    begin
      ent_t        q[$];
      int          flush_left = 0;
      bit          rv_exp = 0;
      logic [31:0] rpc_exp = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        int          k, sel;
        bit          taken, stall_e, resolve, is_cf;
        logic [31:0] target, anext, pnext;
        logic [31:0] pool [6];
        pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, $urandom};
        k = $urandom_range(0, 4);
        ex_valid = ($urandom_range(0, 9) < 8);
        ex_stall = ($urandom_range(0, 9) == 0);
        upd_ready = ($urandom_range(0, 9) < 6);
        branch_EX = (k < 2); is_jal_EX = (k == 2); is_jalr_EX = (k == 3);
        func3_EX = 3'($urandom_range(0, 7));
        pc_EX = {$urandom_range(0, 32'hFFFF), 2'b00};
        imm_EX = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) : $urandom;
        rs1_val = pool[$urandom_range(0, 5)];
        rs2_val = ($urandom_range(0, 2) == 0) ? rs1_val : pool[$urandom_range(0, 5)];
        ghr_EX = $urandom;
        prediction_valid_EX = ($urandom_range(0, 1) != 0);
        ref_resolve(branch_EX, is_jal_EX, is_jalr_EX, func3_EX, pc_EX, imm_EX, rs1_val,
                    rs2_val, taken, target);
        anext = taken ? target : pc_EX + 32'd4;
        sel = $urandom_range(0, 2);
        predicted_pc_EX = (sel == 0) ? anext : (sel == 1) ? pc_EX + 32'd4 : $urandom;
        #1;

        stall_e = (q.size() == UpdDepth) && !upd_ready;
        check("rnd_stall_req", {31'b0, stall_req}, {31'b0, stall_e});
        check("rnd_upd_valid", {31'b0, upd_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
          check("rnd_upd_pc", upd_pc, q[0].pc);
          check("rnd_upd_target", upd_target, q[0].target);
          check("rnd_upd_ghr", upd_ghr, q[0].ghr);
          check("rnd_upd_flags", {29'b0, upd_taken, upd_is_cf, upd_mispredict},
                {29'b0, q[0].taken, q[0].is_cf, q[0].mis});
        end
        check("rnd_flush", {30'b0, flush_IF_ID, flush_ID_EX},
              (flush_left > 0) ? 32'd3 : 32'd0);
        check("rnd_redirect_valid", {31'b0, redirect_valid}, {31'b0, rv_exp});
        if (rv_exp) check("rnd_redirect_pc", redirect_pc, rpc_exp);

        // Advance the model across the coming edge.
        is_cf   = (k != 4);
        pnext   = prediction_valid_EX ? predicted_pc_EX : pc_EX + 32'd4;
        resolve = ex_valid && !ex_stall && !stall_e && (flush_left == 0);
        if (q.size() != 0 && upd_ready) void'(q.pop_front());
        if (resolve && (is_cf || prediction_valid_EX))
          q.push_back('{pc_EX, target, ghr_EX, taken, is_cf, anext != pnext});
        rv_exp = 0;
        if (flush_left > 0) begin
          flush_left--;
        end else if (resolve && (anext != pnext)) begin
          flush_left = FlushCycles;
          rv_exp     = 1;
          rpc_exp    = anext;
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
